tablet_fill_ctrl: RTL and testbench

Parametrised successor of the tablet bottling counter chain. It replaces the separate pill counter, bottle counter, comparator and divider with one FSM-driven controller. The controller counts pills into the current bottle, swaps bottles, tracks a running pill total, and supports pause with re-setting and overfill warning. It sits between the front-panel setting logic and the display/actuator drivers.

---
 rtl/tablet_fill_ctrl_pkg.sv | 23 ++
 rtl/tablet_fill_ctrl_if.sv | 46 ++++
 rtl/tablet_fill_ctrl_tick_gen.sv | 49 ++++
 rtl/tablet_fill_ctrl.sv | 157 +++++++++++++++
 tb/tb_tablet_fill_ctrl.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tablet_fill_ctrl_pkg.sv
// tablet_pkg: shared types and defaults for the tablet fill controller.
//   state_t      - FSM state codes, also driven out on the debug state port
//   *_DEFAULT    - default pill clamp and prescaler divide ratio
//   clamp_pills  - effective pill target = min(v, max_v)
// Optional build macro used by the files that import this package: PILL_SENSOR_EN.
package tablet_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FILL   = 3'd1,
        ST_SWAP   = 3'd2,
        ST_PAUSED = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam int unsigned MAX_PILLS_DEFAULT = 50;
    localparam int unsigned TICK_DIV_DEFAULT  = 50000000;

    function automatic int unsigned clamp_pills(input int unsigned v, input int unsigned max_v);
        return (v > max_v) ? max_v : v;
    endfunction

endpackage

// File: rtl/tablet_fill_ctrl_if.sv
// tablet_fill_ctrl_if: front-panel / display bundle of the tablet fill controller.
//   master: panel side, drives start, pause, set_pills, set_bottles (and pill_sense)
//   slave : controller side, drives pill_cnt, bottle_cnt, total, bottle_full,
//           busy, done, warning, state
// Build macro: PILL_SENSOR_EN adds the pill_sense sensor input.
interface tablet_fill_ctrl_if #(
    parameter int unsigned PILL_W = 7,
    parameter int unsigned BOT_W  = 7,
    parameter int unsigned SUM_W  = 10
);
    logic              start;
    logic              pause;
    logic [PILL_W-1:0] set_pills;
    logic [BOT_W-1:0]  set_bottles;
    logic [PILL_W-1:0] pill_cnt;
    logic [BOT_W-1:0]  bottle_cnt;
    logic [SUM_W-1:0]  total;
    logic              bottle_full;
    logic              busy;
    logic              done;
    logic              warning;
    logic [2:0]        state;

`ifdef PILL_SENSOR_EN
    logic              pill_sense;

    modport master (
        output start, pause, set_pills, set_bottles, pill_sense,
        input  pill_cnt, bottle_cnt, total, bottle_full, busy, done, warning, state
    );
    modport slave (
        input  start, pause, set_pills, set_bottles, pill_sense,
        output pill_cnt, bottle_cnt, total, bottle_full, busy, done, warning, state
    );
`else
    modport master (
        output start, pause, set_pills, set_bottles,
        input  pill_cnt, bottle_cnt, total, bottle_full, busy, done, warning, state
    );
    modport slave (
        input  start, pause, set_pills, set_bottles,
        output pill_cnt, bottle_cnt, total, bottle_full, busy, done, warning, state
    );
`endif

endinterface

// File: rtl/tablet_fill_ctrl_tick_gen.sv
// tablet_tick_gen: single-clk pill tick source.
//   clk, reset    - system clock, synchronous active-high reset
//   i_en          - count enable (controller in FILL or SWAP)
//   i_clr         - clear the prescaler at batch start
//   i_pill_sense  - optical sensor input (PILL_SENSOR_EN builds only)
//   o_tick        - one-clk tick
// Build macro: PILL_SENSOR_EN replaces the prescaler with a synchronised sensor edge.
module tablet_tick_gen
    import tablet_pkg::*;
#(
    parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic i_en,
    input  logic i_clr,
`ifdef PILL_SENSOR_EN
    input  logic i_pill_sense,
`endif
    output logic o_tick
);

`ifdef PILL_SENSOR_EN
    // [0],[1]: synchroniser; [2]: previous synchronised value for edge detect
    logic [2:0] r_sync;

    always_ff @(posedge clk) begin
        if (reset) r_sync <= '0;
        else       r_sync <= {r_sync[1:0], i_pill_sense};
    end

    assign o_tick = i_en & ~i_clr & r_sync[1] & ~r_sync[2];
`else
    localparam int unsigned CNT_W = $clog2(TICK_DIV);

    logic [CNT_W-1:0] r_cnt;
    logic             w_wrap;

    assign w_wrap = (r_cnt == CNT_W'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (reset || i_clr) r_cnt <= '0;
        else if (i_en)      r_cnt <= w_wrap ? '0 : r_cnt + CNT_W'(1);
    end

    assign o_tick = i_en & w_wrap;
`endif

endmodule

// File: rtl/tablet_fill_ctrl.sv
// tablet_fill_ctrl: counts pills into bottles, swaps bottles, keeps a running
// pill total, supports pause with re-setting of the pill target and flags overfill.
//   clk, reset - system clock, synchronous active-high reset
//   ctl        - tablet_fill_ctrl_if.slave: panel inputs in, counts/flags/state out
// Build macro: PILL_SENSOR_EN counts sensor edges instead of prescaler ticks and
// makes SWAP last a single clk.
module tablet_fill_ctrl
    import tablet_pkg::*;
#(
    parameter int unsigned PILL_W    = 7,
    parameter int unsigned BOT_W     = 7,
    parameter int unsigned SUM_W     = 10,
    parameter int unsigned MAX_PILLS = MAX_PILLS_DEFAULT,
    parameter int unsigned TICK_DIV  = TICK_DIV_DEFAULT
) (
    input logic              clk,
    input logic              reset,
    tablet_fill_ctrl_if.slave ctl
);

    state_t            r_state, w_state_nxt;
    state_t            r_ret, w_ret_nxt;
    logic [PILL_W-1:0] r_pill, w_pill_nxt;
    logic [BOT_W-1:0]  r_bot, w_bot_nxt;
    logic [SUM_W-1:0]  r_total, w_total_nxt;
    logic [PILL_W-1:0] r_ptgt, w_ptgt_nxt;
    logic [BOT_W-1:0]  r_btgt, w_btgt_nxt;
    logic              r_full, w_full_nxt;
    logic              r_start_d;

    logic              w_start_edge;
    logic              w_tick;
    logic              w_swap_end;
    logic              w_clr;
    logic              w_en;
    logic [PILL_W-1:0] w_ptgt_live;

    assign w_start_edge = ctl.start & ~r_start_d;
    assign w_ptgt_live  = PILL_W'(clamp_pills(32'(ctl.set_pills), MAX_PILLS));
    assign w_en         = (r_state == ST_FILL) || (r_state == ST_SWAP);

    tablet_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk          (clk),
        .reset        (reset),
        .i_en         (w_en),
        .i_clr        (w_clr),
`ifdef PILL_SENSOR_EN
        .i_pill_sense (ctl.pill_sense),
`endif
        .o_tick       (w_tick)
    );

`ifdef PILL_SENSOR_EN
    assign w_swap_end = 1'b1;
`else
    assign w_swap_end = w_tick;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_ret_nxt   = r_ret;
        w_pill_nxt  = r_pill;
        w_bot_nxt   = r_bot;
        w_total_nxt = r_total;
        w_ptgt_nxt  = r_ptgt;
        w_btgt_nxt  = r_btgt;
        w_full_nxt  = 1'b0;
        w_clr       = 1'b0;

        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_start_edge && (w_ptgt_live != '0) && (ctl.set_bottles != '0)) begin
                    w_pill_nxt  = '0;
                    w_bot_nxt   = '0;
                    w_ptgt_nxt  = w_ptgt_live;
                    w_btgt_nxt  = ctl.set_bottles;
                    w_clr       = 1'b1;
                    w_state_nxt = ST_FILL;
                end
            end
            ST_FILL: begin
                if (ctl.pause) begin
                    w_ret_nxt   = ST_FILL;
                    w_state_nxt = ST_PAUSED;
                end else if (w_tick) begin
                    w_pill_nxt  = r_pill + PILL_W'(1);
                    w_total_nxt = r_total + SUM_W'(1);
                    if (w_pill_nxt == r_ptgt) begin
                        w_full_nxt  = 1'b1;
                        w_bot_nxt   = r_bot + BOT_W'(1);
                        w_state_nxt = (w_bot_nxt == r_btgt) ? ST_DONE : ST_SWAP;
                    end
                end
            end
            ST_SWAP: begin
                if (ctl.pause) begin
                    w_ret_nxt   = ST_SWAP;
                    w_state_nxt = ST_PAUSED;
                end else if (w_swap_end) begin
                    w_pill_nxt  = '0;
                    w_state_nxt = ST_FILL;
                end
            end
            ST_PAUSED: begin
                if (!ctl.pause) begin
                    w_ptgt_nxt = w_ptgt_live;
                    // A lowered target may already be met: close the bottle on release
                    if ((r_ret == ST_FILL) && (r_pill >= w_ptgt_live)) begin
                        w_full_nxt  = 1'b1;
                        w_bot_nxt   = r_bot + BOT_W'(1);
                        w_state_nxt = (w_bot_nxt == r_btgt) ? ST_DONE : ST_SWAP;
                    end else begin
                        w_state_nxt = r_ret;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_ret     <= ST_IDLE;
            r_pill    <= '0;
            r_bot     <= '0;
            r_total   <= '0;
            r_ptgt    <= '0;
            r_btgt    <= '0;
            r_full    <= 1'b0;
            r_start_d <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ret     <= w_ret_nxt;
            r_pill    <= w_pill_nxt;
            r_bot     <= w_bot_nxt;
            r_total   <= w_total_nxt;
            r_ptgt    <= w_ptgt_nxt;
            r_btgt    <= w_btgt_nxt;
            r_full    <= w_full_nxt;
            r_start_d <= ctl.start;
        end
    end

    assign ctl.pill_cnt    = r_pill;
    assign ctl.bottle_cnt  = r_bot;
    assign ctl.total       = r_total;
    assign ctl.bottle_full = r_full;
    assign ctl.busy        = (r_state == ST_FILL) || (r_state == ST_SWAP) || (r_state == ST_PAUSED);
    assign ctl.done        = (r_state == ST_DONE);
    // While paused the operator sees the effect of a new setting before release
    assign ctl.warning     = (r_state == ST_PAUSED) ? (r_pill > w_ptgt_live) : (r_pill > r_ptgt);
    assign ctl.state       = r_state;

endmodule

// File: tb/tb_tablet_fill_ctrl.sv
// tb_tablet_fill_ctrl: directed and randomised stimulus for tablet_fill_ctrl,
// checked every clk against a behavioural model of the bottling rules.
// Build macro: PILL_SENSOR_EN switches the bench to sensor-pulse stimulus.
module tb_tablet_fill_ctrl;

    localparam int TICK_DIV = 2;
    localparam int MAXP     = 50;
    localparam int SUMMOD   = 1024;

    localparam int S_IDLE = 0, S_FILL = 1, S_SWAP = 2, S_PAUSED = 3, S_DONE = 4;

    logic clk;
    logic reset;

    tablet_fill_ctrl_if #(.PILL_W(7), .BOT_W(7), .SUM_W(10)) ctl ();

    tablet_fill_ctrl #(
        .PILL_W    (7),
        .BOT_W     (7),
        .SUM_W     (10),
        .MAX_PILLS (MAXP),
        .TICK_DIV  (TICK_DIV)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .ctl   (ctl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned total_n = 0;
    int unsigned bad_n   = 0;

    // Behavioural model state
    int m_st = S_IDLE, m_ret = S_IDLE;
    int m_pill = 0, m_bot = 0, m_total = 0, m_ptgt = 0, m_btgt = 0;
    int m_full = 0, m_start_d = 0, m_pre = 0;
    int m_s1 = 0, m_s2 = 0, m_s3 = 0;
    int nfull = 0;
    bit auto_sense = 1'b1;

    function automatic int clampv(input int v);
        return (v > MAXP) ? MAXP : v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_n++;
        assert (obs === exp) else begin
            bad_n++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Closes the current bottle; the batch ends once the bottle target is reached.
    task automatic close_bottle();
        m_full = 1;
        m_bot  = m_bot + 1;
        m_st   = (m_bot == m_btgt) ? S_DONE : S_SWAP;
    endtask

    task automatic model_step();
        bit tick, edge_s, swap_end;
        edge_s = ctl.start && (m_start_d == 0);
`ifdef PILL_SENSOR_EN
        tick     = (m_s2 == 1) && (m_s3 == 0);
        swap_end = 1'b1;
`else
        tick     = (m_pre == TICK_DIV - 1);
        swap_end = tick;
`endif
        m_full = 0;
        if (reset) begin
            m_st = S_IDLE; m_ret = S_IDLE; m_pill = 0; m_bot = 0; m_total = 0;
            m_ptgt = 0; m_btgt = 0; m_start_d = 0; m_pre = 0;
            m_s1 = 0; m_s2 = 0; m_s3 = 0;
            return;
        end
        m_s3 = m_s2; m_s2 = m_s1;
`ifdef PILL_SENSOR_EN
        m_s1 = int'(ctl.pill_sense);
`endif
        if (m_st == S_FILL || m_st == S_SWAP) m_pre = (m_pre + 1) % TICK_DIV;
        case (m_st)
            S_IDLE, S_DONE: begin
                if (edge_s && clampv(int'(ctl.set_pills)) > 0 && ctl.set_bottles != 0) begin
                    m_pill = 0; m_bot = 0; m_pre = 0;
                    m_ptgt = clampv(int'(ctl.set_pills));
                    m_btgt = int'(ctl.set_bottles);
                    m_st   = S_FILL;
                end
            end
            S_FILL: begin
                if (ctl.pause) begin
                    m_ret = S_FILL; m_st = S_PAUSED;
                end else if (tick) begin
                    m_pill  = m_pill + 1;
                    m_total = (m_total + 1) % SUMMOD;
                    if (m_pill == m_ptgt) close_bottle();
                end
            end
            S_SWAP: begin
                if (ctl.pause) begin
                    m_ret = S_SWAP; m_st = S_PAUSED;
                end else if (swap_end) begin
                    m_pill = 0; m_st = S_FILL;
                end
            end
            default: begin
                if (!ctl.pause) begin
                    m_ptgt = clampv(int'(ctl.set_pills));
                    if (m_ret == S_FILL && m_pill >= m_ptgt) close_bottle();
                    else m_st = m_ret;
                end
            end
        endcase
        m_start_d = int'(ctl.start);
    endtask

    task automatic compare_all();
        int warn;
        warn = (m_st == S_PAUSED) ? int'(m_pill > clampv(int'(ctl.set_pills))) : int'(m_pill > m_ptgt);
        chk("pill_cnt",    32'(ctl.pill_cnt),    m_pill);
        chk("bottle_cnt",  32'(ctl.bottle_cnt),  m_bot);
        chk("total",       32'(ctl.total),       m_total);
        chk("bottle_full", 32'(ctl.bottle_full), m_full);
        chk("busy",        32'(ctl.busy),        int'(m_st == S_FILL || m_st == S_SWAP || m_st == S_PAUSED));
        chk("done",        32'(ctl.done),        int'(m_st == S_DONE));
        chk("warning",     32'(ctl.warning),     warn);
        chk("state",       32'(ctl.state),       m_st);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
        if (ctl.bottle_full) nfull++;
`ifdef PILL_SENSOR_EN
        if (auto_sense) ctl.pill_sense = ~ctl.pill_sense;
`endif
    endtask

    task automatic pulse_start();
        ctl.start = 1'b1;
        cyc();
        ctl.start = 1'b0;
        cyc();
    endtask

    initial begin
        reset = 1'b1;
        ctl.start = 1'b0;
        ctl.pause = 1'b0;
        ctl.set_pills = '0;
        ctl.set_bottles = '0;
`ifdef PILL_SENSOR_EN
        ctl.pill_sense = 1'b0;
`endif
        cyc();
        cyc();
        chk("reset_state", 32'(ctl.state), S_IDLE);
        reset = 1'b0;
        cyc();

        // 3 pills x 2 bottles
        ctl.set_pills = 7'd3;
        ctl.set_bottles = 7'd2;
        nfull = 0;
        pulse_start();
        for (int n = 0; n < 200 && m_st != S_DONE; n++) cyc();
        chk("t1_done", 32'(ctl.done), 1);
        chk("t1_bottles", 32'(ctl.bottle_cnt), 2);
        chk("t1_total", 32'(ctl.total), 6);
        chk("t1_fulls", nfull, 2);

        // clamp: 60 requested, 50 effective; restart from DONE
        ctl.set_pills = 7'd60;
        ctl.set_bottles = 7'd1;
        pulse_start();
        for (int n = 0; n < 400 && m_st != S_DONE; n++) cyc();
        chk("t2_pill50", 32'(ctl.pill_cnt), 50);
        chk("t2_total", 32'(ctl.total), 56);

        // zero targets are ignored in IDLE
        reset = 1'b1; cyc(); reset = 1'b0; cyc();
        ctl.set_pills = 7'd0;
        pulse_start();
        chk("t3_p0_state", 32'(ctl.state), S_IDLE);
        chk("t3_p0_busy", 32'(ctl.busy), 0);
        ctl.set_pills = 7'd5;
        ctl.set_bottles = 7'd0;
        pulse_start();
        chk("t3_b0_state", 32'(ctl.state), S_IDLE);

        // pause at pill 4, lower target to 3, release
        ctl.set_pills = 7'd10;
        ctl.set_bottles = 7'd3;
        pulse_start();
        for (int n = 0; n < 100 && !(m_pill == 4 && m_st == S_FILL); n++) cyc();
        ctl.pause = 1'b1;
        for (int n = 0; n < 20; n++) cyc();
        chk("t4_frozen", 32'(ctl.pill_cnt), 4);
        chk("t4_paused", 32'(ctl.state), S_PAUSED);
        ctl.set_pills = 7'd3;
        cyc();
        chk("t4_warn", 32'(ctl.warning), 1);
        ctl.pause = 1'b0;
        cyc();
        chk("t4_full", 32'(ctl.bottle_full), 1);
        chk("t4_bot", 32'(ctl.bottle_cnt), 1);
        chk("t4_swap", 32'(ctl.state), S_SWAP);
        for (int n = 0; n < 20 && m_st != S_FILL; n++) cyc();
        chk("t4_clear", 32'(ctl.pill_cnt), 0);
        chk("t4_warn0", 32'(ctl.warning), 0);

        // reset mid-FILL
        for (int n = 0; n < 100 && !(m_pill == 2 && m_st == S_FILL); n++) cyc();
        reset = 1'b1;
        cyc();
        chk("t5_state", 32'(ctl.state), S_IDLE);
        chk("t5_total", 32'(ctl.total), 0);
        chk("t5_pill", 32'(ctl.pill_cnt), 0);
        reset = 1'b0;
        cyc();

        // total wrap: 50 x 21 = 1050 pills; start while busy is ignored
        ctl.set_pills = 7'd50;
        ctl.set_bottles = 7'd21;
        pulse_start();
        for (int n = 0; n < 3000 && m_total != 500; n++) cyc();
        pulse_start();
        chk("t6_busy", 32'(ctl.busy), 1);
        for (int n = 0; n < 3000 && m_total != 1023; n++) cyc();
        chk("t6_1023", 32'(ctl.total), 1023);
        for (int n = 0; n < 20 && m_total != 0; n++) cyc();
        chk("t6_wrap", 32'(ctl.total), 0);
        for (int n = 0; n < 3000 && m_st != S_DONE; n++) cyc();
        chk("t6_total", 32'(ctl.total), 26);
        chk("t6_bots", 32'(ctl.bottle_cnt), 21);
        ctl.set_pills = 7'd2;
        ctl.set_bottles = 7'd1;
        pulse_start();
        for (int n = 0; n < 100 && m_st != S_DONE; n++) cyc();
        chk("t6_kept", 32'(ctl.total), 28);

`ifdef PILL_SENSOR_EN
        // sensor pulses while paused are dropped
        auto_sense = 1'b0;
        ctl.pill_sense = 1'b0;
        ctl.set_pills = 7'd3;
        ctl.set_bottles = 7'd1;
        pulse_start();
        ctl.pause = 1'b1;
        cyc(); cyc();
        for (int k = 0; k < 4; k++) begin
            ctl.pill_sense = 1'b1; cyc(); cyc();
            ctl.pill_sense = 1'b0; cyc(); cyc();
        end
        chk("s_paused", 32'(ctl.pill_cnt), 0);
        ctl.pause = 1'b0;
        cyc();
        nfull = 0;
        for (int k = 0; k < 3; k++) begin
            ctl.pill_sense = 1'b1; cyc(); cyc();
            ctl.pill_sense = 1'b0; cyc(); cyc();
        end
        cyc(); cyc();
        chk("s_full", nfull, 1);
        chk("s_done", 32'(ctl.done), 1);
`endif

        // randomised operation
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 15) == 0) ctl.pause = ~ctl.pause;
            if ($urandom_range(0, 7) == 0)  ctl.start = ~ctl.start;
            if ($urandom_range(0, 9) == 0)
                ctl.set_pills = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(0, 63))
                                                            : 7'($urandom_range(0, 6));
            if ($urandom_range(0, 9) == 0)  ctl.set_bottles = 7'($urandom_range(0, 3));
            reset = ($urandom_range(0, 299) == 0);
`ifdef PILL_SENSOR_EN
            auto_sense = 1'b0;
            if ($urandom_range(0, 2) == 0) ctl.pill_sense = ~ctl.pill_sense;
`endif
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total_n, bad_n);
        $finish;
    end

endmodule
